// File: rtl/blit_pkg.sv
// ============================================================================
// Module      : blit_pkg
// Description : Shared types and default geometry for the sprite blitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package blit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

    localparam int SPR_W_DEFAULT = 50;
    localparam int SPR_H_DEFAULT = 64;
    localparam int FB_W_DEFAULT  = 320;
    localparam int FB_H_DEFAULT  = 240;
    localparam int DRAIN_CYCLES  = 2;

endpackage

`default_nettype wire

// File: rtl/blit_dest_calc.sv
// ============================================================================
// Module      : blit_dest_calc
// Description : Maps a sprite pixel (sx, sy) at (pos_x, pos_y) to a frame
//               buffer address, with optional mirroring and bounds flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blit_dest_calc #(
    parameter int SPR_W = 50,
    parameter int SX_W  = 6,
    parameter int SY_W  = 6,
    parameter int FB_W  = 320,
    parameter int FB_H  = 240,
    parameter int FB_AW = 17
) (
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic [SX_W-1:0]  sx,
    input  logic [SY_W-1:0]  sy,
    input  logic             flip,
    output logic [FB_AW-1:0] fb_addr,
    output logic             in_bounds
);

    localparam logic [10:0] c_SPR_W_M1 = 11'(SPR_W - 1);

    logic [10:0] w_dx;
    logic [10:0] w_fx;
    logic [10:0] w_fy;

    // 11-bit coordinates so a sprite hanging past the right/bottom edge
    // cannot wrap back into the visible area.
    always_comb begin
        w_dx      = flip ? (c_SPR_W_M1 - 11'(sx)) : 11'(sx);
        w_fx      = {1'b0, pos_x} + w_dx;
        w_fy      = {1'b0, pos_y} + 11'(sy);
        in_bounds = (w_fx < 11'(FB_W)) && (w_fy < 11'(FB_H));
        fb_addr   = FB_AW'(w_fy) * FB_AW'(FB_W) + FB_AW'(w_fx);
    end

endmodule

`default_nettype wire

// File: rtl/sprite_blitter.sv
// ============================================================================
// Module      : sprite_blitter
// Description : Copies one palette-indexed sprite from ROM into the frame
//               buffer with mirroring and clipping. Optional macro
//               BLIT_TRANSPARENCY_EN skips pixels equal to TRANSP_IDX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_blitter
    import blit_pkg::*;
#(
    parameter int SPR_W      = SPR_W_DEFAULT,
    parameter int SPR_H      = SPR_H_DEFAULT,
    parameter int SROM_AW    = 12,
    parameter int FB_W       = FB_W_DEFAULT,
    parameter int FB_H       = FB_H_DEFAULT,
    parameter int FB_AW      = 17,
    parameter int IDX_W      = 3,
    parameter int TRANSP_IDX = 0
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               start,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               flip_x,
    output logic               busy,
    output logic               done,
    output logic [SROM_AW-1:0] srom_addr,
    input  logic [IDX_W-1:0]   srom_q,
    output logic               fb_we,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [IDX_W-1:0]   fb_wdata
);

    localparam int                 c_SX_W      = $clog2(SPR_W);
    localparam int                 c_SY_W      = $clog2(SPR_H);
    localparam int                 c_DR_W      = $clog2(DRAIN_CYCLES);
    localparam logic [SROM_AW-1:0] c_LAST_ADDR = SROM_AW'(SPR_W * SPR_H - 1);
    localparam logic [c_SX_W-1:0]  c_SX_LAST   = c_SX_W'(SPR_W - 1);
    localparam logic [c_DR_W-1:0]  c_DR_LAST   = c_DR_W'(DRAIN_CYCLES - 1);
`ifdef BLIT_TRANSPARENCY_EN
    localparam bit                 c_TRANSP_EN = 1'b1;
`else
    localparam bit                 c_TRANSP_EN = 1'b0;
`endif

    blit_state_t        r_state;
    blit_state_t        w_next;
    logic [9:0]         r_pos_x;
    logic [9:0]         r_pos_y;
    logic               r_flip;
    logic [c_SX_W-1:0]  r_sx;
    logic [c_SY_W-1:0]  r_sy;
    logic [c_DR_W-1:0]  r_drain_cnt;
    logic               r_s1_valid;
    logic [c_SX_W-1:0]  r_s1_sx;
    logic [c_SY_W-1:0]  r_s1_sy;
    logic [FB_AW-1:0]   w_dest_addr;
    logic               w_in_bounds;
    logic               w_opaque;
    logic               w_write;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (srom_addr == c_LAST_ADDR) w_next = DRAIN;
            DRAIN:   if (r_drain_cnt == c_DR_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // Read-side counters: linear ROM address plus its (sx, sy) decomposition.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            srom_addr   <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_flip      <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pos_x     <= pos_x;
                        r_pos_y     <= pos_y;
                        r_flip      <= flip_x;
                        srom_addr   <= '0;
                        r_sx        <= '0;
                        r_sy        <= '0;
                        r_drain_cnt <= '0;
                    end
                end
                RUN: begin
                    if (srom_addr != c_LAST_ADDR) srom_addr <= srom_addr + SROM_AW'(1);
                    if (r_sx == c_SX_LAST) begin
                        r_sx <= '0;
                        r_sy <= r_sy + c_SY_W'(1);
                    end else begin
                        r_sx <= r_sx + c_SX_W'(1);
                    end
                end
                DRAIN:   r_drain_cnt <= r_drain_cnt + c_DR_W'(1);
                default: ;
            endcase
        end
    end

    // Stage 1 lines up with srom_q, which arrives one cycle after its address.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sx    <= '0;
            r_s1_sy    <= '0;
        end else begin
            r_s1_valid <= (r_state == RUN);
            r_s1_sx    <= r_sx;
            r_s1_sy    <= r_sy;
        end
    end

    blit_dest_calc #(
        .SPR_W (SPR_W),
        .SX_W  (c_SX_W),
        .SY_W  (c_SY_W),
        .FB_W  (FB_W),
        .FB_H  (FB_H),
        .FB_AW (FB_AW)
    ) u_dest (
        .pos_x     (r_pos_x),
        .pos_y     (r_pos_y),
        .sx        (r_s1_sx),
        .sy        (r_s1_sy),
        .flip      (r_flip),
        .fb_addr   (w_dest_addr),
        .in_bounds (w_in_bounds)
    );

    assign w_opaque = !c_TRANSP_EN || (srom_q != IDX_W'(TRANSP_IDX));
    assign w_write  = r_s1_valid && w_in_bounds && w_opaque;

    // Address and data only move on a real write so skipped pixels leave them stable.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
        end else begin
            fb_we <= w_write;
            if (w_write) begin
                fb_addr  <= w_dest_addr;
                fb_wdata <= srom_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// ============================================================================
// Module      : tb_sprite_blitter
// Description : Scoreboard bench for sprite_blitter (default geometry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_blitter;

`ifdef BLIT_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [9:0]  pos_x   = '0;
    logic [9:0]  pos_y   = '0;
    logic        flip_x  = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] srom_addr;
    logic [2:0]  srom_q  = '0;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_wdata;

    sprite_blitter dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .start     (start),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .flip_x    (flip_x),
        .busy      (busy),
        .done      (done),
        .srom_addr (srom_addr),
        .srom_q    (srom_q),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  rom_mode = 0;

    // Observations recorded by run_blit
    int   n_we, first_we_cyc, last_we_cyc, done_cyc, done_cnt;
    int   first_addr, first_data, addr49, last_addr, we_after_rst;
    logic busy_c1, busy_at_done, idle_ok, we_at_rst, busy_at_rst;
    logic [11:0] srom_c1;

    function automatic int rom_val(int a);
        if (rom_mode == 0) return (a % 7) + 1;
        return (a == 100) ? 5 : 0;
    endfunction

    always @(posedge vga_clk) srom_q <= 3'(rom_val(int'(srom_addr)));

    always @(negedge vga_clk) begin : monitor
        wr_t e;
        if (!reset && fb_we) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL fb_write_unexpected: got addr=%0d data=%0d, expected no write",
                         fb_addr, fb_wdata);
            end else begin
                e = sb.pop_front();
                if (fb_addr !== 17'(e.addr) || fb_wdata !== 3'(e.data)) begin
                    failures++;
                    $display("FAIL fb_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             fb_addr, fb_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_expected(input int px, input int py, input bit flip);
        for (int a = 0; a < 3200; a++) begin
            int sx, sy, dx, fx, fy, d;
            sx = a % 50;
            sy = a / 50;
            dx = flip ? 49 - sx : sx;
            fx = px + dx;
            fy = py + sy;
            d  = rom_val(a);
            if (fx < 320 && fy < 240 && !(TRANSP_EN && d == 0))
                sb.push_back('{fy * 320 + fx, d});
        end
    endtask

    // Starts a blit (edge 0 = next posedge) and records cycles 1..3204.
    task automatic run_blit(input int px, input int py, input bit flip,
                            input bit hold, input int pulse_at, input int rst_at);
        n_we = 0; first_we_cyc = -1; last_we_cyc = -1; done_cyc = -1; done_cnt = 0;
        first_addr = -1; first_data = -1; addr49 = -1; last_addr = -1; we_after_rst = 0;
        busy_c1 = 1'b0; busy_at_done = 1'bx; idle_ok = 1'b0; we_at_rst = 1'bx; busy_at_rst = 1'bx;
        pos_x = 10'(px); pos_y = 10'(py); flip_x = flip; start = 1'b1;
        @(posedge vga_clk);
        for (int k = 1; k <= 3204; k++) begin
            @(negedge vga_clk);
            if (k == 1 && !hold) start = 1'b0;
            if (k == pulse_at) start = 1'b1;
            if (pulse_at > 0 && k == pulse_at + 1) start = 1'b0;
            if (rst_at > 0 && k == rst_at + 1) reset = 1'b0;
            if (k == 1) begin
                busy_c1 = busy;
                srom_c1 = srom_addr;
            end
            if (fb_we && !reset) begin
                if (n_we == 0) begin
                    first_we_cyc = k; first_addr = int'(fb_addr); first_data = int'(fb_wdata);
                end
                if (n_we == 49) addr49 = int'(fb_addr);
                last_we_cyc = k;
                last_addr   = int'(fb_addr);
                if (rst_at > 0 && k > rst_at) we_after_rst++;
                n_we++;
            end
            if (done) begin
                done_cnt++;
                done_cyc     = k;
                busy_at_done = busy;
            end
            if (k == 3204) idle_ok = !busy && !done;
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                we_at_rst   = fb_we;
                busy_at_rst = busy;
                sb.delete();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge vga_clk);
        checks++;
        if ({busy, done, fb_we} !== 3'b000 || fb_addr !== '0 || fb_wdata !== '0 || srom_addr !== '0) begin
            failures++;
            $display("FAIL reset_values: got busy=%b done=%b we=%b addr=%0d data=%0d srom=%0d, expected all 0",
                     busy, done, fb_we, fb_addr, fb_wdata, srom_addr);
        end
        reset = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic test_basic();
        rom_mode = 0;
        push_expected(0, 0, 1'b0);
        run_blit(0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (busy_c1 !== 1'b1 || srom_c1 !== 12'd0) begin
            failures++;
            $display("FAIL basic_cycle1: got busy=%b srom_addr=%0d, expected busy=1 srom_addr=0", busy_c1, srom_c1);
        end
        checks++;
        if (n_we !== 3200) begin
            failures++;
            $display("FAIL basic_count: got %0d writes, expected 3200", n_we);
        end
        checks++;
        if (first_we_cyc !== 3 || first_addr !== 0 || first_data !== 1) begin
            failures++;
            $display("FAIL basic_first: got cycle=%0d addr=%0d data=%0d, expected cycle=3 addr=0 data=1",
                     first_we_cyc, first_addr, first_data);
        end
        checks++;
        if (last_we_cyc !== 3202 || last_addr !== 20209) begin
            failures++;
            $display("FAIL basic_last: got cycle=%0d addr=%0d, expected cycle=3202 addr=20209", last_we_cyc, last_addr);
        end
        checks++;
        if (done_cyc !== 3203 || done_cnt !== 1 || busy_at_done !== 1'b0 || idle_ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_done: got cycle=%0d pulses=%0d busy=%b idle=%b, expected cycle=3203 pulses=1 busy=0 idle=1",
                     done_cyc, done_cnt, busy_at_done, idle_ok);
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL basic_missing: got %0d writes outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_flip();
        rom_mode = 0;
        push_expected(10, 5, 1'b1);
        run_blit(10, 5, 1'b1, 1'b0, 0, 0);
        checks++;
        if (first_addr !== 1659 || addr49 !== 1610) begin
            failures++;
            $display("FAIL flip_addr: got rom0->%0d rom49->%0d, expected 1659 and 1610", first_addr, addr49);
        end
        checks++;
        if (n_we !== 3200 || sb.size() !== 0) begin
            failures++;
            $display("FAIL flip_count: got %0d writes, %0d outstanding, expected 3200 and 0", n_we, sb.size());
        end
    endtask

    task automatic test_clip();
        rom_mode = 0;
        push_expected(300, 220, 1'b0);
        run_blit(300, 220, 1'b0, 1'b0, 0, 0);
        checks++;
        if (n_we !== 400 || sb.size() !== 0) begin
            failures++;
            $display("FAIL clip_count: got %0d writes, %0d outstanding, expected 400 and 0", n_we, sb.size());
        end
        checks++;
        if (done_cyc !== 3203 || done_cnt !== 1) begin
            failures++;
            $display("FAIL clip_done: got cycle=%0d pulses=%0d, expected cycle=3203 pulses=1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_transparency();
        int exp_n, exp_addr, exp_data;
        rom_mode = 1;
        exp_n    = TRANSP_EN ? 1 : 3200;
        exp_addr = TRANSP_EN ? 640 : 0;
        exp_data = TRANSP_EN ? 5 : 0;
        push_expected(0, 0, 1'b0);
        run_blit(0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (n_we !== exp_n || first_addr !== exp_addr || first_data !== exp_data) begin
            failures++;
            $display("FAIL transp: got n=%0d addr=%0d data=%0d, expected n=%0d addr=%0d data=%0d",
                     n_we, first_addr, first_data, exp_n, exp_addr, exp_data);
        end
        checks++;
        if (done_cyc !== 3203 || sb.size() !== 0) begin
            failures++;
            $display("FAIL transp_done: got cycle=%0d outstanding=%0d, expected cycle=3203 outstanding=0",
                     done_cyc, sb.size());
        end
        rom_mode = 0;
    endtask

    task automatic test_reset_mid();
        rom_mode = 0;
        push_expected(0, 0, 1'b0);
        run_blit(0, 0, 1'b0, 1'b0, 0, 1000);
        checks++;
        if (we_at_rst !== 1'b0 || busy_at_rst !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_now: got we=%b busy=%b, expected 0 and 0", we_at_rst, busy_at_rst);
        end
        checks++;
        if (done_cnt !== 0 || we_after_rst !== 0) begin
            failures++;
            $display("FAIL reset_mid_after: got done=%0d writes=%0d, expected 0 and 0", done_cnt, we_after_rst);
        end
        push_expected(0, 0, 1'b0);
        run_blit(0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (n_we !== 3200 || done_cyc !== 3203 || sb.size() !== 0) begin
            failures++;
            $display("FAIL reset_mid_rerun: got n=%0d done=%0d outstanding=%0d, expected 3200 3203 0",
                     n_we, done_cyc, sb.size());
        end
    endtask

    task automatic test_start_ignored();
        logic busy_seen;
        rom_mode = 0;
        push_expected(0, 0, 1'b0);
        run_blit(0, 0, 1'b0, 1'b0, 500, 0);
        checks++;
        if (n_we !== 3200 || done_cnt !== 1 || done_cyc !== 3203) begin
            failures++;
            $display("FAIL start_ignored: got n=%0d pulses=%0d done=%0d, expected 3200 1 3203",
                     n_we, done_cnt, done_cyc);
        end
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge vga_clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored_idle: got busy=1 after blit, expected 0");
        end
    endtask

    task automatic test_back_to_back();
        rom_mode = 0;
        push_expected(0, 0, 1'b0);
        push_expected(10, 5, 1'b1);
        run_blit(0, 0, 1'b0, 1'b1, 0, 0);
        checks++;
        if (done_cyc !== 3203 || idle_ok !== 1'b1 || sb.size() !== 3200) begin
            failures++;
            $display("FAIL b2b_first: got done=%0d idle=%b outstanding=%0d, expected 3203 1 3200",
                     done_cyc, idle_ok, sb.size());
        end
        run_blit(10, 5, 1'b1, 1'b0, 0, 0);
        checks++;
        if (busy_c1 !== 1'b1 || n_we !== 3200 || done_cyc !== 3203 || sb.size() !== 0) begin
            failures++;
            $display("FAIL b2b_second: got busy=%b n=%0d done=%0d outstanding=%0d, expected 1 3200 3203 0",
                     busy_c1, n_we, done_cyc, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flip();
        test_clip();
        test_transparency();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
